uart_rx: RTL and testbench

- 16x-oversampling UART receiver; the receive-side counterpart of the UART core's transmitter.
- Shares the core's baud-rate generator `s_tick`.
- Deserialises LSB-first frames: start bit, DBIT data bits, optional parity bit, stop period.
- Presents each received byte with a one-cycle done pulse and per-frame error flags to the UART core's RX FIFO.

---
 rtl/uart_rx.sv | 138 +++++++++++++
 tb/tb_uart_rx.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver: LSB-first frames with optional parity.
// Presents each word with a one-cycle done pulse and per-frame error flags.
module uart_rx #(
  parameter int unsigned DBIT       = 8,
  parameter int unsigned SB_TICK    = 16,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            rx,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            frame_err,
  output logic            parity_err
);

  localparam int unsigned NW = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [4:0]    S_MID  = 5'd7;
  localparam logic [4:0]    S_END  = 5'd15;
  localparam logic [4:0]    S_STOP = 5'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);
  localparam logic          PAR_ON = (PARITY_EN != 0);
  localparam logic          PAR_OD = 1'(PARITY_ODD);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_e;

  state_e          state_q;
  logic [4:0]      s_q;
  logic [NW-1:0]   n_q;
  logic [DBIT-1:0] b_q;
  logic            p_q;
  logic            stop_bad_q;
  logic            stop_bad_d;
  logic            rx_meta_q;
  logic            rx_s_q;
  logic [DBIT-1:0] dout_q;
  logic            done_q;
  logic            ferr_q;
  logic            perr_q;

  // With a one-bit stop period the midpoint sample and completion coincide.
  assign stop_bad_d = (s_q == S_END) ? ~rx_s_q : stop_bad_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      state_q    <= IDLE;
      s_q        <= '0;
      n_q        <= '0;
      b_q        <= '0;
      p_q        <= 1'b0;
      stop_bad_q <= 1'b0;
      dout_q     <= '0;
      done_q     <= 1'b0;
      ferr_q     <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      done_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!rx_s_q) begin
            s_q     <= '0;
            p_q     <= 1'b0;
            state_q <= START;
          end
        end
        START: begin
          if (s_tick) begin
            if (s_q == S_MID) begin
              if (!rx_s_q) begin
                s_q     <= '0;
                n_q     <= '0;
                state_q <= DATA;
              end else begin
                state_q <= IDLE;
              end
            end else begin
              s_q <= s_q + 5'd1;
            end
          end
        end
        DATA: begin
          if (s_tick) begin
            if (s_q == S_END) begin
              s_q <= '0;
              b_q <= {rx_s_q, b_q[DBIT-1:1]};
              p_q <= p_q ^ rx_s_q;
              if (n_q == N_LAST) begin
                state_q <= PAR_ON ? PAR : STOP;
              end else begin
                n_q <= n_q + NW'(1);
              end
            end else begin
              s_q <= s_q + 5'd1;
            end
          end
        end
        PAR: begin
          if (s_tick) begin
            if (s_q == S_END) begin
              s_q     <= '0;
              p_q     <= p_q ^ rx_s_q;
              state_q <= STOP;
            end else begin
              s_q <= s_q + 5'd1;
            end
          end
        end
        STOP: begin
          if (s_tick) begin
            stop_bad_q <= stop_bad_d;
            if (s_q == S_STOP) begin
              done_q  <= 1'b1;
              dout_q  <= b_q;
              ferr_q  <= stop_bad_d;
              perr_q  <= PAR_ON & (p_q ^ PAR_OD);
              state_q <= IDLE;
            end else begin
              s_q <= s_q + 5'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dout         = dout_q;
  assign rx_done_tick = done_q;
  assign frame_err    = ferr_q;
  assign parity_err   = perr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Randomised bench for uart_rx: 8N1 and 8O1 instances against a frame-level scoreboard.
module tb_uart_rx;

  typedef struct {
    logic [7:0]      d;
    logic            fe;
    logic            pe;
    longint unsigned t;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       s_tick = 1'b0;
  logic [1:0] div = 2'd0;
  logic       rx_a = 1'b1;
  logic       rx_b = 1'b1;
  logic [7:0] dout_a, dout_b;
  logic       done_a, done_b, ferr_a, ferr_b, perr_a, perr_b;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t e_a, e_b;
  int   n_checks = 0;
  int   n_fail = 0;
  int   pulses_a = 0;
  int   pulses_b = 0;
  int   sent_a = 0;
  int   sent_b = 0;
  int   lat_a, lat_b;
  logic prev_a = 1'b0;
  logic prev_b = 1'b0;

  always #5 clk = ~clk;

  // One-clk s_tick every 4 clk
  always @(posedge clk) begin
    div    <= div + 2'd1;
    s_tick <= (div == 2'd3);
  end

  uart_rx #(.DBIT(8), .SB_TICK(16), .PARITY_EN(0), .PARITY_ODD(0)) dut_a (
    .clk(clk), .reset(reset), .s_tick(s_tick), .rx(rx_a),
    .dout(dout_a), .rx_done_tick(done_a), .frame_err(ferr_a), .parity_err(perr_a)
  );

  uart_rx #(.DBIT(8), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(1)) dut_b (
    .clk(clk), .reset(reset), .s_tick(s_tick), .rx(rx_b),
    .dout(dout_b), .rx_done_tick(done_b), .frame_err(ferr_b), .parity_err(perr_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard for the 8N1 instance: word, flags and start-to-pulse latency
  always @(negedge clk) begin
    if (done_a === 1'b1) begin
      pulses_a++;
      check("a_done_width", 32'(prev_a), 32'd0);
      if (q_a.size() == 0) begin
        check("a_unexpected_pulse", 32'd1, 32'd0);
      end else begin
        e_a = q_a.pop_front();
        check("a_dout", 32'(dout_a), 32'(e_a.d));
        check("a_frame_err", 32'(ferr_a), 32'(e_a.fe));
        check("a_parity_err", 32'(perr_a), 32'd0);
        lat_a = int'(($time - e_a.t) / 10);
        check("a_latency_in_window", 32'(lat_a >= 606 && lat_a <= 614), 32'd1);
      end
    end
    prev_a = done_a;
  end

  // Scoreboard for the 8O1 instance
  always @(negedge clk) begin
    if (done_b === 1'b1) begin
      pulses_b++;
      check("b_done_width", 32'(prev_b), 32'd0);
      if (q_b.size() == 0) begin
        check("b_unexpected_pulse", 32'd1, 32'd0);
      end else begin
        e_b = q_b.pop_front();
        check("b_dout", 32'(dout_b), 32'(e_b.d));
        check("b_frame_err", 32'(ferr_b), 32'(e_b.fe));
        check("b_parity_err", 32'(perr_b), 32'(e_b.pe));
        lat_b = int'(($time - e_b.t) / 10);
        check("b_latency_in_window", 32'(lat_b >= 670 && lat_b <= 678), 32'd1);
      end
    end
    prev_b = done_b;
  end

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_rx(input bit which, input logic v);
    if (which) rx_b = v;
    else rx_a = v;
  endtask

  // Called on a negedge; one bit = 16 ticks = 64 clk. A bad stop bit is
  // held low past its midpoint, followed by a gap long enough for the
  // receiver to reject the trailing low as a glitch.
  task automatic send_frame(input bit which, input logic [7:0] data,
                            input logic pbit, input bit bad_stop);
    exp_t e;
    set_rx(which, 1'b0);
    e.d  = data;
    e.fe = bad_stop;
    e.t  = $time;
    e.pe = which ? ((($countones(data) + int'(pbit)) % 2) == 0) : 1'b0;
    if (which) begin
      q_b.push_back(e);
      sent_b++;
    end else begin
      q_a.push_back(e);
      sent_a++;
    end
    hold(64);
    for (int i = 0; i < 8; i++) begin
      set_rx(which, data[i]);
      hold(64);
    end
    if (which) begin
      set_rx(which, pbit);
      hold(64);
    end
    if (bad_stop) begin
      set_rx(which, 1'b0);
      hold(48);
      set_rx(which, 1'b1);
      hold(16 + 192);
    end else begin
      set_rx(which, 1'b1);
      hold(64);
    end
  endtask

  initial begin
    logic [7:0] ff_byte;
    hold(3);
    check("rst_dout_a", 32'(dout_a), 32'd0);
    check("rst_done_a", 32'(done_a), 32'd0);
    check("rst_ferr_a", 32'(ferr_a), 32'd0);
    check("rst_perr_a", 32'(perr_a), 32'd0);
    check("rst_dout_b", 32'(dout_b), 32'd0);
    check("rst_perr_b", 32'(perr_b), 32'd0);
    hold(2);
    reset = 1'b1;
    hold(20);

    // Start-bit glitch of 3 ticks
    set_rx(1'b0, 1'b0);
    hold(12);
    set_rx(1'b0, 1'b1);
    hold(200);
    check("glitch_no_pulse", 32'(pulses_a), 32'd0);
    check("glitch_dout_kept", 32'(dout_a), 32'd0);

    send_frame(1'b0, 8'hA5, 1'b0, 1'b0);
    hold(40);
    check("a5_one_pulse", 32'(pulses_a), 32'd1);

    send_frame(1'b0, 8'h3C, 1'b0, 1'b0);
    send_frame(1'b0, 8'hC3, 1'b0, 1'b0);
    send_frame(1'b0, 8'h55, 1'b0, 1'b1);
    send_frame(1'b0, 8'h12, 1'b0, 1'b0);
    check("frame_err_cleared", 32'(ferr_a), 32'd0);

    send_frame(1'b1, 8'h07, 1'b0, 1'b0);
    hold(20);
    check("odd_par_ok", 32'(perr_b), 32'd0);
    send_frame(1'b1, 8'h07, 1'b1, 1'b0);
    hold(20);
    check("odd_par_bad", 32'(perr_b), 32'd1);
    check("odd_par_dout", 32'(dout_b), 32'h07);

    // Reset in the middle of data bit 4 of 0xFF
    ff_byte = 8'hFF;
    set_rx(1'b0, 1'b0);
    hold(64);
    for (int i = 0; i < 4; i++) begin
      set_rx(1'b0, ff_byte[i]);
      hold(64);
    end
    set_rx(1'b0, ff_byte[4]);
    hold(32);
    reset = 1'b0;
    hold(3);
    check("midrst_dout_a", 32'(dout_a), 32'd0);
    check("midrst_done_a", 32'(done_a), 32'd0);
    check("midrst_ferr_a", 32'(ferr_a), 32'd0);
    check("midrst_perr_b", 32'(perr_b), 32'd0);
    check("midrst_dout_b", 32'(dout_b), 32'd0);
    set_rx(1'b0, 1'b1);
    hold(5);
    reset = 1'b1;
    hold(700);
    check("midrst_no_pulse", 32'(pulses_a), 32'(sent_a));
    send_frame(1'b0, 8'h81, 1'b0, 1'b0);

    for (int k = 0; k < 16; k++) begin
      send_frame(1'b0, 8'($urandom), 1'b0, ($urandom_range(0, 3) == 0));
      hold(int'($urandom_range(0, 20)));
    end
    for (int k = 0; k < 12; k++) begin
      send_frame(1'b1, 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
      hold(int'($urandom_range(0, 20)));
    end

    for (int i = 0; i < 3000 && (q_a.size() != 0 || q_b.size() != 0); i++) hold(1);
    hold(50);
    check("a_queue_drained", 32'(q_a.size()), 32'd0);
    check("b_queue_drained", 32'(q_b.size()), 32'd0);
    check("a_pulse_count", 32'(pulses_a), 32'(sent_a));
    check("b_pulse_count", 32'(pulses_b), 32'(sent_b));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
